// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle: op in, decoded fields out.
// The master side drives in_valid/op/out_ready; the decode stage (slave) drives the rest.
interface decode_stage_if #(
    parameter int INSTR_W = 32,
    parameter int RA_W    = 4,
    parameter int IMM_W   = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] op;
    logic               out_valid;
    logic               out_ready;
    logic               alu_out;
    logic               comp_out;
    logic               misc_cs;
    logic               maybe_jmp;
    logic               use_r1;
    logic               use_r2;
    logic               reg_we;
    logic [RA_W-1:0]    r1_addr;
    logic [RA_W-1:0]    r2_addr;
    logic [RA_W-1:0]    rw_addr;
    logic [IMM_W-1:0]   default_a1;
    logic [IMM_W-1:0]   default_a2;
    logic [3:0]         optype;

    modport master (
        output in_valid, op, out_ready,
        input  in_ready, out_valid, alu_out, comp_out, misc_cs, maybe_jmp,
               use_r1, use_r2, reg_we, r1_addr, r2_addr, rw_addr,
               default_a1, default_a2, optype
    );

    modport slave (
        input  in_valid, op, out_ready,
        output in_ready, out_valid, alu_out, comp_out, misc_cs, maybe_jmp,
               use_r1, use_r2, reg_we, r1_addr, r2_addr, rw_addr,
               default_a1, default_a2, optype
    );
endinterface

// File: rtl/decode_stage.sv
// Registered decode with pending-write scoreboard; 1-cycle latency, 1 op/cycle when hazard-free.
// Backpressure: in_ready drops on RAW/WAW hazard, flush, or a held output that execute has not taken.
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int RA_W    = 4,
    parameter int IMM_W   = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    decode_stage_if.slave    bus,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [RA_W-1:0]  wb_addr,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int NREG = 1 << RA_W;

    logic [1:0]      kind;
    logic            dec_use_r1;
    logic            dec_use_r2;
    logic            dec_we;
    logic [RA_W-1:0] dec_rw;
    logic [RA_W-1:0] dec_r1;
    logic [RA_W-1:0] dec_r2;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_eff;
    logic [NREG-1:0] wb_mask;
    logic [NREG-1:0] flush_mask;
    logic [NREG-1:0] set_mask;
    logic            hazard;
    logic            accept;

    assign kind       = bus.op[5:4];
    assign dec_use_r1 = bus.op[6];
    assign dec_use_r2 = bus.op[7];
    assign dec_rw     = bus.op[8 +: RA_W];
    assign dec_r1     = bus.op[12 +: RA_W];
    assign dec_r2     = bus.op[INSTR_W-RA_W +: RA_W];
    assign dec_we     = (kind[0] == kind[1]) || (kind == 2'b10 && !bus.op[0]);

    always_comb begin
        wb_mask    = '0;
        flush_mask = '0;
        set_mask   = '0;
        if (wb_valid)
            wb_mask[wb_addr] = 1'b1;
        // A flushed instruction never writes back, so its reservation must be released here.
        if (flush && bus.out_valid && bus.reg_we)
            flush_mask[bus.rw_addr] = 1'b1;
        if (accept && dec_we)
            set_mask[dec_rw] = 1'b1;
    end

    // Same-cycle writeback bypasses the scoreboard for the hazard check.
    assign pend_eff = pending & ~wb_mask;
    assign hazard   = (dec_use_r1 && pend_eff[dec_r1]) ||
                      (dec_use_r2 && pend_eff[dec_r2]) ||
                      (dec_we     && pend_eff[dec_rw]);

    assign bus.in_ready = !hazard && (!bus.out_valid || bus.out_ready) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign stall        = bus.in_valid && hazard;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending        <= '0;
            stall_cnt      <= '0;
            bus.out_valid  <= 1'b0;
            bus.alu_out    <= 1'b0;
            bus.comp_out   <= 1'b0;
            bus.misc_cs    <= 1'b0;
            bus.maybe_jmp  <= 1'b0;
            bus.use_r1     <= 1'b0;
            bus.use_r2     <= 1'b0;
            bus.reg_we     <= 1'b0;
            bus.r1_addr    <= '0;
            bus.r2_addr    <= '0;
            bus.rw_addr    <= '0;
            bus.default_a1 <= '0;
            bus.default_a2 <= '0;
            bus.optype     <= '0;
        end else begin
            // Set is applied last so it wins over a same-cycle clear.
            pending <= (pending & ~wb_mask & ~flush_mask) | set_mask;

            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;

            if (flush)
                bus.out_valid <= 1'b0;
            else if (accept)
                bus.out_valid <= 1'b1;
            else if (bus.out_ready)
                bus.out_valid <= 1'b0;

            if (accept) begin
                bus.alu_out    <= (kind == 2'b00);
                bus.maybe_jmp  <= (kind == 2'b01);
                bus.misc_cs    <= (kind == 2'b10);
                bus.comp_out   <= (kind == 2'b11);
                bus.use_r1     <= dec_use_r1;
                bus.use_r2     <= dec_use_r2;
                bus.reg_we     <= dec_we;
                bus.r1_addr    <= dec_r1;
                bus.r2_addr    <= dec_r2;
                bus.rw_addr    <= dec_rw;
                bus.default_a1 <= bus.op[12 +: IMM_W];
                bus.default_a2 <= bus.op[INSTR_W-IMM_W +: IMM_W];
                bus.optype     <= bus.op[3:0];
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a scoreboard model.
module tb_decode_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wb_valid;
    logic [3:0] wb_addr;
    logic       stall;
    logic [3:0] stall_cnt;

    always #5 clk = ~clk;

    decode_stage_if #(.INSTR_W(32), .RA_W(4), .IMM_W(16)) bus ();

    decode_stage #(.INSTR_W(32), .RA_W(4), .IMM_W(16), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Model state: scoreboard, issued-instruction slot, stall counter.
    bit          m_pend[16];
    bit          m_valid;
    logic [54:0] m_fields;
    int          m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field layout: alu,comp,misc,jmp,use_r1,use_r2,reg_we | r1 | r2 | rw | a1 | a2 | optype
    function automatic logic [54:0] dec(input logic [31:0] op);
        logic alu, jmp, misc, comp, we;
        alu  = (op[5:4] == 2'd0);
        jmp  = (op[5:4] == 2'd1);
        misc = (op[5:4] == 2'd2);
        comp = (op[5:4] == 2'd3);
        we   = alu || comp || (misc && (op[3:0] % 2 == 0));
        return {alu, comp, misc, jmp, op[6], op[7], we,
                op[15:12], op[31:28], op[11:8], op[27:12], op[31:16], op[3:0]};
    endfunction

    function automatic logic [54:0] dut_fields();
        return {bus.alu_out, bus.comp_out, bus.misc_cs, bus.maybe_jmp, bus.use_r1, bus.use_r2,
                bus.reg_we, bus.r1_addr, bus.r2_addr, bus.rw_addr, bus.default_a1,
                bus.default_a2, bus.optype};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_valid  = 1'b0;
        m_fields = '0;
        m_cnt    = 0;
    endtask

    // Called just after a falling edge with inputs applied; returns after the next falling edge.
    task automatic step();
        logic [54:0] f;
        bit          pe[16];
        bit          haz, exp_rdy, exp_stall, acc;
        f = dec(bus.op);
        for (int i = 0; i < 16; i++)
            pe[i] = m_pend[i] && !(wb_valid && wb_addr == i);
        haz = (f[50] && pe[f[47:44]]) || (f[49] && pe[f[43:40]]) || (f[48] && pe[f[39:36]]);
        exp_rdy   = !haz && (!m_valid || bus.out_ready) && !flush;
        exp_stall = bus.in_valid && haz;
        #1;
        check("in_ready", bus.in_ready, exp_rdy);
        check("stall", stall, exp_stall);
        check("out_valid", bus.out_valid, m_valid);
        check("stall_cnt", stall_cnt, m_cnt);
        if (m_valid) check("fields", dut_fields(), m_fields);
        acc = bus.in_valid && exp_rdy;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (wb_valid) m_pend[wb_addr] = 1'b0;
            if (flush && m_valid && m_fields[48]) m_pend[m_fields[39:36]] = 1'b0;
            if (acc && f[48]) m_pend[f[39:36]] = 1'b1;
            if (exp_stall && m_cnt < 15) m_cnt++;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid  = 1'b1;
                m_fields = f;
            end else if (bus.out_ready) m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] o;
        rst_n = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_addr = '0;
        bus.in_valid = 1'b0; bus.op = '0; bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_fields", dut_fields(), 55'd0);
        rst_n = 1'b1;
        step();

        // Write to r3 reserves it.
        bus.op = 32'h0000_0300; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        check("w3_reg_we", bus.reg_we, 1'b1);
        check("w3_rw", bus.rw_addr, 4'd3);

        // Read of r3 stalls until writeback, which bypasses in the same cycle.
        bus.op = 32'h0000_3040;
        repeat (3) step();
        check("raw_cnt", stall_cnt, 4'd3);
        wb_valid = 1'b1; wb_addr = 4'd3;
        step();
        wb_valid = 1'b0;
        check("raw_issue_r1", bus.r1_addr, 4'd3);
        check("raw_issue_vld", bus.out_valid, 1'b1);

        // Execute backpressure holds the output.
        bus.op = 32'h0000_0010; bus.out_ready = 1'b0;
        repeat (3) step();
        check("hold_r1", bus.r1_addr, 4'd3);
        bus.out_ready = 1'b1;
        step();
        check("bp_jmp", bus.maybe_jmp, 1'b1);

        // Flush of held r5 writer releases r5.
        bus.op = 32'h0000_0500;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_vld", bus.out_valid, 1'b0);
        bus.op = 32'h0000_5050; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        check("post_flush_r1", bus.r1_addr, 4'd5);

        // Misc ops: optype 0 writes, optype 1 does not reserve.
        bus.op = 32'h0000_0720;
        step();
        check("misc0_cs", bus.misc_cs, 1'b1);
        check("misc0_we", bus.reg_we, 1'b1);
        bus.op = 32'h0000_0921;
        step();
        check("misc1_we", bus.reg_we, 1'b0);
        bus.op = 32'h9000_0090;
        step();
        check("r9_free", bus.r2_addr, 4'd9);

        // Stall counter saturation.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.op = 32'h0000_0300;
        step();
        bus.op = 32'h0000_3040;
        repeat (18) step();
        check("sat_cnt", stall_cnt, 4'hF);

        // Randomized traffic with register fields biased to collide.
        rst_n = 1'b0;
        step();
        for (int c = 0; c < 1500; c++) begin
            o = $urandom;
            o[11:8]  = 4'($urandom_range(0, 3));
            o[15:12] = 4'($urandom_range(0, 3));
            o[31:28] = 4'($urandom_range(0, 3));
            bus.op        = o;
            rst_n         = ($urandom_range(0, 199) != 0);
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 19) == 0);
            wb_valid      = ($urandom_range(0, 9) < 4);
            wb_addr       = 4'($urandom_range(0, 4));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
